// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    PA,
    P2A,
    NA,
    N2A
  } booth_t;

  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 modified Booth recoder: three multiplier bits select a
// sign-extended 34-bit addend from {0, +A, +2A, -A, -2A}.
module booth_recode
  import multdiv_pkg::*;
(
  input  logic [2:0]  bits,
  input  logic [31:0] a,
  output logic [33:0] addend
);

  booth_t      sel;
  logic [33:0] ax;

  assign ax = {{2{a[31]}}, a};

  always_comb begin
    sel = ZERO;
    unique case (bits)
      3'b001, 3'b010: sel = PA;
      3'b011:         sel = P2A;
      3'b100:         sel = N2A;
      3'b101, 3'b110: sel = NA;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    unique case (sel)
      PA:      addend = ax;
      P2A:     addend = ax << 1;
      NA:      addend = -ax;
      N2A:     addend = -(ax << 1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/iter_multdiv.sv
// Iterative signed 32-bit multiplier (radix-4 Booth) and divider
// (restoring, on magnitudes) with a one-cycle completion pulse.
module iter_multdiv #(
  parameter int MULT_ITERS = 16,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  import multdiv_pkg::*;

  state_t      state;
  logic [5:0]  cnt;
  logic [64:0] prod;
  logic [63:0] rq;
  logic [31:0] mcand;
  logic [31:0] dvsr;
  logic        q_neg;
  logic        div_ovf;
  logic        op_div;

  logic [33:0] addend;
  logic [33:0] psum;
  logic [64:0] pshift;
  logic [63:0] rsh;
  logic [63:0] rnext;
  logic [31:0] q;
  logic [31:0] div_res;
  logic        m_exc;
  logic        start;
  logic        m_last;
  logic        d_last;

  booth_recode u_booth (
    .bits   (prod[2:0]),
    .a      (mcand),
    .addend (addend)
  );

  assign psum   = {{2{prod[64]}}, prod[64:33]} + addend;
  assign pshift = {psum, prod[32:2]};

  // Restoring step: shift, then subtract the divisor if it fits.
  assign rsh   = rq << 1;
  assign rnext = (rsh[63:32] >= dvsr)
               ? {rsh[63:32] - dvsr, rsh[31:1], 1'b1}
               : rsh;

  assign q       = rq[31:0];
  assign div_res = (dvsr == '0) ? '0 : (q_neg ? -q : q);
  assign m_exc   = ~((&prod[64:32]) | ~(|prod[64:32]));

  assign start  = ctrl_MULT | ctrl_DIV;
  assign m_last = cnt == 6'(MULT_ITERS - 1);
  assign d_last = cnt == 6'(DIV_ITERS - 1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      prod           <= '0;
      rq             <= '0;
      mcand          <= '0;
      dvsr           <= '0;
      q_neg          <= 1'b0;
      div_ovf        <= 1'b0;
      op_div         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == DONE) begin
        data_result    <= op_div ? div_res : prod[32:1];
        data_exception <= op_div ? ((dvsr == '0) | div_ovf) : m_exc;
        data_resultRDY <= 1'b1;
      end
      if (start) begin
        state   <= ctrl_MULT ? MULT : DIV;
        op_div  <= ~ctrl_MULT;
        cnt     <= '0;
        prod    <= {32'b0, data_operandB, 1'b0};
        mcand   <= data_operandA;
        rq      <= {32'b0, mag(data_operandA)};
        dvsr    <= mag(data_operandB);
        q_neg   <= data_operandA[31] ^ data_operandB[31];
        div_ovf <= (data_operandA == INT_MIN) &&
                   (data_operandB == 32'hFFFF_FFFF);
      end else begin
        case (state)
          MULT: begin
            prod <= pshift;
            cnt  <= cnt + 6'd1;
            if (m_last) state <= DONE;
          end
          DIV: begin
            rq  <= rnext;
            cnt <= cnt + 6'd1;
            if (d_last) state <= DONE;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
